// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller: IF/DEC/EXE/MEM/WB sequencer that drives
// datapath strobes and counts retired instructions.
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_rdy,
    output logic             pcwr,
    output logic             irwr,
    output logic             regwr,
    output logic             memwr,
    output logic             memrd,
    output logic             regdst,
    output logic             alusrc,
    output logic             memtoreg,
    output logic             extop,
    output logic             illegal,
    output logic [1:0]       npc_sel,
    output logic [2:0]       aluctr,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       dbg_state_o
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_DEC = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [5:0]       funct_q, funct_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;

    logic       is_r, is_ori, is_lw, is_sw, is_beq, is_j;
    logic [2:0] r_alu;

    always_comb begin
        r_alu = 3'b000;
        is_r  = 1'b0;
        if (op_q == 6'b000000) begin
            is_r = 1'b1;
            case (funct_q)
                6'b100001: r_alu = 3'b000;
                6'b100011: r_alu = 3'b100;
                6'b100101: r_alu = 3'b010;
                6'b101010: r_alu = 3'b111;
                6'b101011: r_alu = 3'b110;
                default:   is_r  = 1'b0;
            endcase
        end
        is_ori = (op_q == 6'b001101);
        is_lw  = (op_q == 6'b100011);
        is_sw  = (op_q == 6'b101011);
        is_beq = (op_q == 6'b000100);
        is_j   = (op_q == 6'b000010);
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        funct_d  = funct_q;
        retire   = 1'b0;
        pcwr     = 1'b0;
        irwr     = 1'b0;
        regwr    = 1'b0;
        memwr    = 1'b0;
        memrd    = 1'b0;
        regdst   = 1'b0;
        alusrc   = 1'b0;
        memtoreg = 1'b0;
        extop    = 1'b0;
        illegal  = 1'b0;
        npc_sel  = 2'b00;
        aluctr   = 3'b000;
        case (state_q)
            S_IF: begin
                memrd = 1'b1;
                // Gated by rst_n so a held reset shows only the idle fetch read.
                if (mem_rdy && rst_n) begin
                    irwr    = 1'b1;
                    pcwr    = 1'b1;
                    op_d    = op;
                    funct_d = funct;
                    state_d = S_DEC;
                end
            end
            S_DEC: begin
                if (is_j) begin
                    pcwr    = 1'b1;
                    npc_sel = 2'b10;
                    retire  = 1'b1;
                    state_d = S_IF;
                end else if (is_r || is_ori || is_lw || is_sw || is_beq) begin
                    state_d = S_EXE;
                end else begin
                    illegal = 1'b1;
                    state_d = S_IF;
                end
            end
            S_EXE: begin
                if (is_beq) begin
                    aluctr  = 3'b100;
                    pcwr    = zero;
                    npc_sel = 2'b01;
                    retire  = 1'b1;
                    state_d = S_IF;
                end else if (is_lw || is_sw) begin
                    alusrc  = 1'b1;
                    extop   = 1'b1;
                    state_d = S_MEM;
                end else if (is_ori) begin
                    aluctr  = 3'b010;
                    alusrc  = 1'b1;
                    state_d = S_WB;
                end else begin
                    aluctr  = r_alu;
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (is_lw) begin
                    memrd = 1'b1;
                    if (mem_rdy) state_d = S_WB;
                end else if (is_sw) begin
                    memwr = 1'b1;
                    if (mem_rdy) begin
                        retire  = 1'b1;
                        state_d = S_IF;
                    end
                end else begin
                    state_d = S_IF;
                end
            end
            S_WB: begin
                regwr    = 1'b1;
                regdst   = is_r;
                memtoreg = is_lw;
                retire   = 1'b1;
                state_d  = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IF;
            op_q      <= 6'd0;
            funct_q   <= 6'd0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            funct_q   <= funct_d;
            instret_q <= instret_d;
        end
    end

    assign instret     = instret_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: the driver pushes one expected output vector per
// cycle, a negedge monitor pops and compares against two instances (CNT_W=32 and 4).
module tb_mc_ctrl;

  localparam int W = 54;

  localparam logic [9:0] P  = 10'b1000000000;
  localparam logic [9:0] I  = 10'b0100000000;
  localparam logic [9:0] RW = 10'b0010000000;
  localparam logic [9:0] MW = 10'b0001000000;
  localparam logic [9:0] MR = 10'b0000100000;
  localparam logic [9:0] RD = 10'b0000010000;
  localparam logic [9:0] AS = 10'b0000001000;
  localparam logic [9:0] MT = 10'b0000000100;
  localparam logic [9:0] EX = 10'b0000000010;
  localparam logic [9:0] IL = 10'b0000000001;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] op, funct;
  logic zero, mem_rdy;

  logic pcwr, irwr, regwr, memwr, memrd, regdst, alusrc, memtoreg, extop, illegal;
  logic [1:0] npc_sel;
  logic [2:0] aluctr, dbg_state;
  logic [31:0] instret;

  logic pcwr_b, irwr_b, regwr_b, memwr_b, memrd_b, regdst_b, alusrc_b, memtoreg_b, extop_b, illegal_b;
  logic [1:0] npc_sel_b;
  logic [2:0] aluctr_b, dbg_state_b;
  logic [3:0] instret_b;

  logic [W-1:0] exp_q[$];
  string name_q[$];
  logic [31:0] cnt;
  int checks = 0;
  int passes = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mc_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
    .pcwr(pcwr), .irwr(irwr), .regwr(regwr), .memwr(memwr), .memrd(memrd),
    .regdst(regdst), .alusrc(alusrc), .memtoreg(memtoreg), .extop(extop),
    .illegal(illegal), .npc_sel(npc_sel), .aluctr(aluctr), .instret(instret),
    .dbg_state_o(dbg_state)
  );

  mc_ctrl #(.CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_rdy(mem_rdy),
    .pcwr(pcwr_b), .irwr(irwr_b), .regwr(regwr_b), .memwr(memwr_b), .memrd(memrd_b),
    .regdst(regdst_b), .alusrc(alusrc_b), .memtoreg(memtoreg_b), .extop(extop_b),
    .illegal(illegal_b), .npc_sel(npc_sel_b), .aluctr(aluctr_b), .instret(instret_b),
    .dbg_state_o(dbg_state_b)
  );

  // The narrow instance contributes only its counter; its control outputs match the wide one.
  wire [W-1:0] act = {dbg_state, npc_sel, aluctr, pcwr, irwr, regwr, memwr, memrd,
                      regdst, alusrc, memtoreg, extop, illegal, instret, instret_b};

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (act === e) passes++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, e, $time);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [17:0] c(input logic [2:0] st, input logic [1:0] npc,
                                    input logic [2:0] alu, input logic [9:0] f);
    return {st, npc, alu, f};
  endfunction

  task automatic cyc(input logic [17:0] ctl, input string nm);
    logic [31:0] v;
    v = cnt;
    exp_q.push_back({ctl, v, v[3:0]});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Fetch, then scramble the bus so later states must use the latched fields.
  task automatic fetch(input logic [5:0] o, input logic [5:0] f, input int wait_n);
    op = o; funct = f; mem_rdy = 1'b0;
    repeat (wait_n) cyc(c(0, 0, 0, MR), "if_wait");
    mem_rdy = 1'b1;
    cyc(c(0, 0, 0, P | I | MR), "if_fetch");
    op = ~o; funct = ~f;
  endtask

  task automatic run_r(input logic [5:0] f, input logic [2:0] alu);
    fetch(6'b000000, f, 1);
    cyc(c(1, 0, 0, 0), "r_dec");
    cyc(c(2, 0, alu, 0), "r_exe");
    cyc(c(4, 0, 0, RW | RD), "r_wb");
    cnt++;
  endtask

  task automatic run_ori();
    fetch(6'b001101, 6'b000000, 0);
    cyc(c(1, 0, 0, 0), "ori_dec");
    cyc(c(2, 0, 3'b010, AS), "ori_exe");
    cyc(c(4, 0, 0, RW), "ori_wb");
    cnt++;
  endtask

  task automatic run_lw(input int wait_n);
    fetch(6'b100011, 6'b000000, 0);
    cyc(c(1, 0, 0, 0), "lw_dec");
    cyc(c(2, 0, 0, AS | EX), "lw_exe");
    mem_rdy = 1'b0;
    repeat (wait_n) cyc(c(3, 0, 0, MR), "lw_mem_wait");
    mem_rdy = 1'b1;
    cyc(c(3, 0, 0, MR), "lw_mem");
    mem_rdy = 1'b0;
    cyc(c(4, 0, 0, RW | MT), "lw_wb");
    cnt++;
  endtask

  task automatic run_sw(input int wait_n);
    fetch(6'b101011, 6'b000000, 0);
    cyc(c(1, 0, 0, 0), "sw_dec");
    cyc(c(2, 0, 0, AS | EX), "sw_exe");
    mem_rdy = 1'b0;
    repeat (wait_n) cyc(c(3, 0, 0, MW), "sw_mem_wait");
    mem_rdy = 1'b1;
    cyc(c(3, 0, 0, MW), "sw_mem");
    cnt++;
  endtask

  task automatic run_beq(input logic z);
    fetch(6'b000100, 6'b000000, 0);
    zero = ~z;
    cyc(c(1, 0, 0, 0), "beq_dec");
    zero = z;
    cyc(c(2, 2'b01, 3'b100, z ? P : 10'b0), "beq_exe");
    cnt++;
  endtask

  task automatic run_j();
    fetch(6'b000010, 6'b000000, 0);
    cyc(c(1, 2'b10, 0, P), "j_dec");
    cnt++;
  endtask

  task automatic run_illegal(input logic [5:0] o, input logic [5:0] f);
    fetch(o, f, 0);
    cyc(c(1, 0, 0, IL), "ill_dec");
    mem_rdy = 1'b0;
    cyc(c(0, 0, 0, MR), "ill_back_if");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_rdy = 1'b1; cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    cyc(c(0, 0, 0, MR), "reset_state");
    rst_n = 1'b1; mem_rdy = 1'b0;
    cyc(c(0, 0, 0, MR), "if_idle");

    run_r(6'b100001, 3'b000);
    run_r(6'b100011, 3'b100);
    run_r(6'b100101, 3'b010);
    run_r(6'b101010, 3'b111);
    run_r(6'b101011, 3'b110);
    run_ori();
    run_lw(3);
    run_lw(0);
    run_sw(2);
    run_beq(1'b1);
    run_beq(1'b0);
    run_j();
    run_illegal(6'b111111, 6'b000000);
    run_illegal(6'b000000, 6'b000000);

    // Reset in the middle of a store: the write strobe must drop and nothing retires.
    fetch(6'b101011, 6'b000000, 0);
    cyc(c(1, 0, 0, 0), "swr_dec");
    cyc(c(2, 0, 0, AS | EX), "swr_exe");
    mem_rdy = 1'b0;
    cyc(c(3, 0, 0, MW), "swr_mem");
    rst_n = 1'b0; mem_rdy = 1'b1; cnt = '0;
    cyc(c(0, 0, 0, MR), "mid_reset");
    rst_n = 1'b1; mem_rdy = 1'b0;
    cyc(c(0, 0, 0, MR), "post_reset");

    // Sixteen jumps wrap the 4-bit counter back to zero.
    for (int k = 0; k < 16; k++) run_j();
    mem_rdy = 1'b0;
    cyc(c(0, 0, 0, MR), "after_wrap");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port op  input  6  instruction bits [31:26] from the instruction bus.
REQ-005 SHALL have port funct  input  6  instruction bits [5:0].
REQ-006 SHALL have port zero  input  1  ALU zero flag.
REQ-007 SHALL have port mem_rdy  input  1  memory access-complete handshake.
REQ-008 SHALL have outputs pcwr, irwr, regwr, memwr, memrd, regdst, alusrc, memtoreg, extop, illegal, each 1 bit, active-high datapath strobes and selects.
REQ-009 SHALL have port npc_sel  output  2  next-PC source: 00=pc+4, 01=branch target, 10=jump target.
REQ-010 SHALL have port aluctr  output  3  ALU operation: 000=add, 010=or, 100=sub, 111=slt, 110=sltu.
REQ-011 SHALL have port instret  output  CNT_W  retired-instruction count.

Function
REQ-012 SHALL implement five states: IF=0, DEC=1, EXE=2, MEM=3, WB=4, held in a registered state vector.
REQ-013 SHALL drive all outputs combinationally from the registered state, latched op/funct, zero and mem_rdy; outputs not listed for a state SHALL be 0.
REQ-014 In IF, SHALL assert memrd and wait while mem_rdy=0. When mem_rdy=1, SHALL assert irwr and pcwr with npc_sel=00, latch op/funct, and go to DEC.
REQ-015 In DEC, SHALL classify the latched op/funct.
- R-type: op=000000 with funct addu=100001, subu=100011, or=100101, slt=101010, sltu=101011.
- ori: op=001101.
- lw: op=100011.
- sw: op=101011.
- beq: op=000100.
- j: op=000010.
REQ-016 In DEC with j, SHALL assert pcwr with npc_sel=10, retire, and go to IF.
REQ-017 In DEC with an unsupported encoding, SHALL assert illegal for exactly one cycle, perform no writes, leave instret unchanged, and go to IF.
REQ-018 In DEC with any other supported instruction, SHALL go to EXE.
REQ-019 In EXE for R-type, SHALL set aluctr from funct (addu=000, subu=100, or=010, slt=111, sltu=110) with alusrc=0, then go to WB.
REQ-020 In EXE for ori, SHALL set aluctr=010, alusrc=1, extop=0, then go to WB.
REQ-021 In EXE for lw/sw, SHALL set aluctr=000, alusrc=1, extop=1, then go to MEM.
REQ-022 In EXE for beq, SHALL set aluctr=100 and alusrc=0; pcwr SHALL equal zero with npc_sel=01; SHALL retire and go to IF.
REQ-023 In MEM for lw, SHALL assert memrd and hold until mem_rdy=1, then go to WB.
REQ-024 In MEM for sw, SHALL assert memwr and hold until mem_rdy=1, then retire and go to IF.
REQ-025 In WB, SHALL assert regwr for exactly one cycle, with regdst=1 for R-type and memtoreg=1 for lw, then retire and go to IF.
REQ-026 Retire SHALL increment instret by 1 at the edge leaving the final state; instret SHALL wrap modulo 2^CNT_W.
REQ-027 Minimum latencies with mem_rdy=1 on the first cycle SHALL be: j 2, beq 3, R-type/ori 4, sw 4, lw 5 cycles.
REQ-028 mem_rdy SHALL be ignored in DEC, EXE and WB.
REQ-029 memwr and regwr SHALL never be asserted in the same cycle.
REQ-030 Unused state encodings 5-7 SHALL transition to IF with all outputs 0.

Reset
REQ-031 rst_n=0 SHALL immediately, without a clock, force state=IF, latched op/funct=0, instret=0, and all outputs 0 except memrd=1, the IF value of memrd.
REQ-032 Reset asserted mid-instruction SHALL abandon that instruction: no further pcwr/regwr/memwr and no retire.
REQ-033 After rst_n rises, the first rising edge SHALL evaluate IF normally.

Verification
REQ-034 After reset, with mem_rdy=1 and addu (op=000000, funct=100001) SHALL produce the state sequence IF,DEC,EXE,WB; aluctr=000 in EXE; regwr=1 and regdst=1 in WB only; instret 0->1.
REQ-035 lw with mem_rdy held low for 3 cycles in MEM SHALL keep MEM with memrd=1 for 4 cycles; then WB with memtoreg=1; total 8 cycles.
REQ-036 beq with zero=1 SHALL give pcwr=1 and npc_sel=01 in EXE; with zero=0, pcwr=0 in EXE; instret +1 in both cases.
REQ-037 op=111111 SHALL give illegal=1 for one cycle in DEC, no pcwr/regwr/memwr after IF, and instret unchanged.
REQ-038 sw with rst_n pulsed low in MEM SHALL drop memwr at once; after release, the bench SHALL observe state IF and instret=0.
REQ-039 With CNT_W=4, 16 j instructions SHALL wrap instret from 15 to 0.
